// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble CPU sequencer: states, opcodes,
// control-word bit positions and ALU select codes.
package nibble_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_CMPI  = 4'h2;
  localparam logic [3:0] OP_CMPM  = 4'h3;
  localparam logic [3:0] OP_LIT   = 4'h4;
  localparam logic [3:0] OP_IN    = 4'h5;
  localparam logic [3:0] OP_LD    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_ADDM  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_OUT   = 4'hD;
  localparam logic [3:0] OP_NANDI = 4'hE;
  localparam logic [3:0] OP_NANDM = 4'hF;

  // Control word: {incPC, loadPC, loadA, loadFlags, S[2:0], csRAM, weRAM, oeALU, oeIN, oeOprnd, loadOut}
  localparam int CW_BITS     = 13;
  localparam int B_INCPC     = 12;
  localparam int B_LOADPC    = 11;
  localparam int B_LOADA     = 10;
  localparam int B_LOADFLAGS = 9;
  localparam int B_S_LSB     = 6;
  localparam int B_CSRAM     = 5;
  localparam int B_WERAM     = 4;
  localparam int B_OEALU     = 3;
  localparam int B_OEIN      = 2;
  localparam int B_OEOPRND   = 1;
  localparam int B_LOADOUT   = 0;

  localparam logic [2:0] S_PASS = 3'b000;
  localparam logic [2:0] S_CMP  = 3'b001;
  localparam logic [2:0] S_LD   = 3'b010;
  localparam logic [2:0] S_ADD  = 3'b011;
  localparam logic [2:0] S_NAND = 3'b100;

  localparam logic [CW_BITS-1:0] FETCH_WORD = 13'h1008;
  // Keeps the ALU select and bus enables, drops every load/increment strobe.
  localparam logic [CW_BITS-1:0] HOLD_MASK  = 13'h01FE;

endpackage

// File: rtl/nibble_decode_rom.sv
// Combinational opcode decoder: full execute control word and RAM-access flag.
module nibble_decode_rom
  import nibble_pkg::*;
(
  input  logic [3:0]         opcode,
  input  logic [1:0]         flags,
  output logic [CW_BITS-1:0] word,
  output logic               is_ram
);

  logic is_jump;
  logic take;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    word    = '0;
    is_ram  = 1'b0;
    is_jump = 1'b0;
    take    = 1'b0;
    case (opcode)
      OP_JC:    begin is_jump = 1'b1; take = flags[1];  end
      OP_JNC:   begin is_jump = 1'b1; take = !flags[1]; end
      OP_JZ:    begin is_jump = 1'b1; take = flags[0];  end
      OP_JNZ:   begin is_jump = 1'b1; take = !flags[0]; end
      OP_JMP:   begin is_jump = 1'b1; take = 1'b1;      end
      OP_CMPI:  begin
        word[B_S_LSB +: 3] = S_CMP;
        word[B_LOADFLAGS]  = 1'b1;
        word[B_OEOPRND]    = 1'b1;
      end
      OP_CMPM:  begin
        word[B_S_LSB +: 3] = S_CMP;
        word[B_INCPC]      = 1'b1;
        word[B_LOADFLAGS]  = 1'b1;
        word[B_CSRAM]      = 1'b1;
        is_ram             = 1'b1;
      end
      OP_LIT:   begin
        word[B_S_LSB +: 3] = S_LD;
        word[B_LOADA]      = 1'b1;
        word[B_LOADFLAGS]  = 1'b1;
        word[B_OEOPRND]    = 1'b1;
      end
      OP_IN:    begin
        word[B_S_LSB +: 3] = S_LD;
        word[B_LOADA]      = 1'b1;
        word[B_LOADFLAGS]  = 1'b1;
        word[B_OEIN]       = 1'b1;
      end
      OP_LD:    begin
        word[B_S_LSB +: 3] = S_LD;
        word[B_INCPC]      = 1'b1;
        word[B_LOADA]      = 1'b1;
        word[B_LOADFLAGS]  = 1'b1;
        word[B_CSRAM]      = 1'b1;
        is_ram             = 1'b1;
      end
      OP_ST:    begin
        word[B_S_LSB +: 3] = S_PASS;
        word[B_INCPC]      = 1'b1;
        word[B_CSRAM]      = 1'b1;
        word[B_WERAM]      = 1'b1;
        word[B_OEALU]      = 1'b1;
        is_ram             = 1'b1;
      end
      OP_ADDI:  begin
        word[B_S_LSB +: 3] = S_ADD;
        word[B_LOADA]      = 1'b1;
        word[B_LOADFLAGS]  = 1'b1;
        word[B_OEOPRND]    = 1'b1;
      end
      OP_ADDM:  begin
        word[B_S_LSB +: 3] = S_ADD;
        word[B_INCPC]      = 1'b1;
        word[B_LOADA]      = 1'b1;
        word[B_LOADFLAGS]  = 1'b1;
        word[B_CSRAM]      = 1'b1;
        is_ram             = 1'b1;
      end
      OP_OUT:   begin
        word[B_LOADOUT]    = 1'b1;
        word[B_OEALU]      = 1'b1;
      end
      OP_NANDI: begin
        word[B_S_LSB +: 3] = S_NAND;
        word[B_LOADA]      = 1'b1;
        word[B_LOADFLAGS]  = 1'b1;
        word[B_OEOPRND]    = 1'b1;
      end
      OP_NANDM: begin
        word[B_S_LSB +: 3] = S_NAND;
        word[B_INCPC]      = 1'b1;
        word[B_LOADA]      = 1'b1;
        word[B_LOADFLAGS]  = 1'b1;
        word[B_CSRAM]      = 1'b1;
        is_ram             = 1'b1;
      end
      default: ;
    endcase
    // A jump either reloads the PC or falls through to the next instruction.
    if (is_jump) begin
      word[B_OEALU]  = 1'b1;
      word[B_LOADPC] = take;
      word[B_INCPC]  = !take;
    end
  end

endmodule

// File: rtl/nibble_sequencer.sv
// Registered fetch/execute sequencer for the nibble CPU with RAM wait states,
// a carry/zero flags register and run/halt/single-step control.
module nibble_sequencer
  import nibble_pkg::*;
#(
  parameter int RAM_WAIT = 0,
  parameter int CW_W     = 13
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      instr,
  input  logic            alu_c,
  input  logic            alu_z,
  input  logic            run,
  input  logic            step,
  output logic            phase,
  output logic            halted,
  output logic [1:0]      flags,
  output logic [CW_W-1:0] ctrl,
  output logic            incpc,
  output logic            loadpc,
  output logic            loada,
  output logic            loadflags,
  output logic [2:0]      s,
  output logic            csram,
  output logic            weram,
  output logic            oealu,
  output logic            oein,
  output logic            oeoprnd,
  output logic            loadout
);

  localparam logic [1:0] FETCH = ST_FETCH;
  localparam logic [1:0] EXEC  = ST_EXEC;
  localparam logic [1:0] WAIT  = ST_WAIT;
  localparam logic [1:0] HALT  = ST_HALT;

  localparam bit         HAS_WAIT  = (RAM_WAIT > 0);
  localparam logic [3:0] WAIT_LOAD = 4'(RAM_WAIT);

  logic [1:0]         state, state_n;
  logic [3:0]         cnt, cnt_n;
  logic [1:0]         flags_q;
  logic [CW_BITS-1:0] full_word;
  logic [CW_BITS-1:0] ctrl_w;
  logic               ram_op;
  logic [1:0]         exit_state;

  nibble_decode_rom u_rom (
    .opcode (instr),
    .flags  (flags_q),
    .word   (full_word),
    .is_ram (ram_op)
  );

  assign exit_state = run ? FETCH : HALT;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ctrl_w  = '0;
    case (state)
      FETCH: begin
        ctrl_w  = FETCH_WORD;
        state_n = EXEC;
      end
      EXEC: begin
        if (ram_op && HAS_WAIT) begin
          ctrl_w  = full_word & HOLD_MASK;
          cnt_n   = WAIT_LOAD;
          state_n = WAIT;
        end else begin
          ctrl_w  = full_word;
          state_n = exit_state;
        end
      end
      WAIT: begin
        // Count 1 marks the final execute cycle: strobes fire only here.
        if (cnt == 4'd1) begin
          ctrl_w  = full_word;
          cnt_n   = '0;
          state_n = exit_state;
        end else begin
          ctrl_w  = full_word & HOLD_MASK;
          cnt_n   = cnt - 4'd1;
        end
      end
      HALT: begin
        if (run || step) state_n = FETCH;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset clears all of it at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      cnt     <= '0;
      flags_q <= 2'b00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (ctrl_w[B_LOADFLAGS]) flags_q <= {alu_c, alu_z};
    end
  end

  assign phase  = (state == EXEC) || (state == WAIT);
  assign halted = (state == HALT);
  assign flags  = flags_q;
  assign ctrl   = CW_W'(ctrl_w);

  assign {incpc, loadpc, loada, loadflags, s, csram, weram,
          oealu, oein, oeoprnd, loadout} = ctrl_w;

endmodule
